seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width; SHALL be a power of two, >= 4.
REQ-002 Parameter: SW (localparam), default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operation request valid.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B.
REQ-009 Port: op  input  3  operation select (REQ-014).
REQ-010 Port: out_valid  output  1  result and flags valid.
REQ-011 Port: out_ready  input  1  consumer takes result this cycle.
REQ-012 Port: out  output  WIDTH  registered result.
REQ-013 Port: flags  output  4  registered {N, Z, C, V}.

Function
REQ-014 op encoding SHALL be: 000 ADD a+b; 001 SUB a-b; 010 AND a&b; 011 NOT ~b; 100 OR a|b; 101 XOR a^b; 110 SHL a<<b[SW-1:0]; 111 MUL, low WIDTH bits of unsigned a*b.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH; no output wider than WIDTH.
REQ-016 State machine SHALL have states IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 iff state==IDLE and reset==0 (combinational from state).
REQ-018 Acceptance SHALL occur on a cycle with in_valid && in_ready; in_a, in_b, op SHALL be captured then; later input changes SHALL NOT affect the operation.
REQ-019 Non-MUL accept: IDLE->DONE; out, flags, out_valid=1 SHALL appear the cycle after acceptance (latency 1).
REQ-020 MUL accept: IDLE->BUSY; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in BUSY; then DONE; out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-021 BUSY SHALL ignore in_valid, op, operands, and out_ready.
REQ-022 DONE: out, flags SHALL hold stable while out_valid && !out_ready (no limit on stall length).
REQ-023 DONE with out_ready=1: SHALL go to IDLE next cycle, out_valid=0; out and flags SHALL retain last value.
REQ-024 No acceptance in the retire cycle (in_ready=0 in DONE); peak throughput one non-MUL op per 2 cycles.
REQ-025 Z SHALL be (out==0); N SHALL be out[WIDTH-1]; for all ops.
REQ-026 C: ADD carry-out; SUB 1 iff a<b unsigned (borrow); MUL 1 iff high WIDTH bits of full product nonzero; other ops 0.
REQ-027 V: ADD/SUB two's-complement signed overflow; all other ops 0.
REQ-028 SHL with b[SW-1:0]==0 SHALL return a unchanged; upper bits of b SHALL be ignored.
REQ-029 MUL by 0 SHALL still take WIDTH BUSY cycles (fixed latency).

Reset
REQ-030 reset high at a clock edge SHALL force state IDLE, out_valid=0, out=0, flags=0, from any state including mid-BUSY (operation aborted, no result emitted).
REQ-031 in_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-032 reset SHALL take priority over simultaneous in_valid or out_ready.

Verification (WIDTH=16 unless stated)
REQ-033 ADD 0xFFFF+0x0001, out_ready=1 -> one cycle later out=0x0000, flags N=0 Z=1 C=1 V=0; IDLE next cycle.
REQ-034 SUB 0x8000-0x0001 -> out=0x7FFF, N=0 Z=0 C=0 V=1; SUB 0x0001-0x0002 -> out=0xFFFF, N=1 C=1 V=0.
REQ-035 MUL 0x0100*0x0100 -> out_valid exactly 17 cycles after accept, out=0x0000, Z=1 C=1; MUL 0x00FF*0x0003 -> out=0x02FD, C=0.
REQ-036 Backpressure: OR 0x0F0F|0x00FF with out_ready=0 for 5 cycles -> out=0x0FFF and out_valid held, in_ready=0 throughout; retires on the cycle out_ready=1.
REQ-037 Reset asserted 4 cycles into a MUL -> next cycle out_valid=0, out=0, flags=0; in_ready=1 cycle after release; new op accepted normally.
REQ-038 SHL 0x0001 by in_b=0x0013 (amount 3) -> out=0x0008; op/operands changed after acceptance -> result unaffected.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: single-request ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish the cycle after acceptance. MUL runs an iterative
// shift-add in BUSY for exactly WIDTH cycles. The result is held in DONE
// until the consumer takes it.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;

  // Multiplier registers: {hi_q, lo_q} is the partial product. lo_q starts
  // as the multiplier and is shifted out one bit per cycle.
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   add_wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;

  // Result and flags of every single-cycle op, computed from the live inputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned and infers a latch.
    add_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        add_wide = {1'b0, in_a} + {1'b0, in_b};
        alu_res  = add_wide[MSB:0];
        alu_c    = add_wide[WIDTH];
        alu_v    = (in_a[MSB] == in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        alu_res = in_a - in_b;
        alu_c   = (in_a < in_b);
        alu_v   = (in_a[MSB] != in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_NOT:  alu_res = ~in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SHL:  alu_res = in_a << in_b[SW-1:0];
      default: alu_res = '0;  // MUL produces its result in BUSY
    endcase
    alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
  end

  // One shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole partial product right by one bit.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[MSB:1]};
  end

  // Next-state logic for the FSM and the registers it controls.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (op_e'(op) == OP_MUL) begin
            state_d = BUSY;
            mcand_d = in_a;
            hi_d    = '0;
            lo_d    = in_b;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            out_d   = alu_res;
            flags_d = alu_flags;
          end
        end
      end
      BUSY: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = mul_lo;
          flags_d = {mul_lo[MSB], (mul_lo == '0), (mul_hi != '0), 1'b0};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and visible outputs; reset has priority over handshakes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  // Multiplier datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. They are always loaded on
    // acceptance, before anything reads them.
    mcand_q <= mcand_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu. Expected results come from a
// behavioural model. They are queued at issue and popped when out_valid rises.
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_w;
  logic [3:0]   flags;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .flags     (flags)
  );

  // Reference model built on integer arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int   sa;
    int   sb;
    int   sr;
    logic c;
    logic v;
    exp_t e;
    sa = $signed(a);
    sb = $signed(b);
    c  = 1'b0;
    v  = 1'b0;
    p  = '0;
    case (o)
      3'd0: begin
        p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        e.res = p[W-1:0];
        c = p[W];
        sr = sa + sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        e.res = a - b;
        c = (a < b);
        sr = sa - sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = ~b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: e.res = a << (b % W);
      default: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        c = (p[2*W-1:W] != 0);
      end
    endcase
    e.flg = {e.res[W-1], (e.res == 0), c, v};
    return e;
  endfunction

  // Wait (bounded) for in_ready. Then present one request for one cycle and
  // queue its expected result.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (in_ready !== 1'b1)
      $display("FAIL issue_ready: in_ready=%b required 1 after %0d cycles", in_ready, waited);
    else n_pass++;
    in_valid = 1'b1;
    op       = o;
    in_a     = a;
    in_b     = b;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles from acceptance until out_valid (1 = cycle after acceptance).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd0;
    in_a      = 16'h1234;
    in_b      = 16'h1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, out_w, flags} !== {1'b0, 1'b0, 16'h0000, 4'h0})
      $display("FAIL reset_state: ready=%b valid=%b out=%h flags=%b required 0 0 0000 0000",
               in_ready, out_valid, out_w, flags);
    else n_pass++;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add();
    int   lat;
    exp_t e;
    issue(3'd0, 16'hFFFF, 16'h0001);
    wait_valid(lat);
    e = sb_q.pop_front();
    n_total++;
    if (lat !== 1) $display("FAIL add_latency: got %0d required 1", lat);
    else n_pass++;
    n_total++;
    if ({out_w, flags} !== {e.res, e.flg} || {out_w, flags} !== {16'h0000, 4'b0110})
      $display("FAIL add_wrap: out=%h flags=%b required out=%h flags=%b", out_w, flags, e.res, e.flg);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready, out_w} !== {1'b0, 1'b1, 16'h0000})
      $display("FAIL add_retire: valid=%b ready=%b out=%h required 0 1 0000", out_valid, in_ready, out_w);
    else n_pass++;
  endtask

  task automatic test_sub();
    logic [W-1:0] ta[2] = '{16'h8000, 16'h0001};
    logic [W-1:0] tb[2] = '{16'h0001, 16'h0002};
    logic [W-1:0] to[2] = '{16'h7FFF, 16'hFFFF};
    logic [3:0]   tf[2] = '{4'b0001, 4'b1010};
    int   lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(3'd1, ta[i], tb[i]);
      wait_valid(lat);
      e = sb_q.pop_front();
      n_total++;
      if (lat !== 1 || {out_w, flags} !== {e.res, e.flg} || {out_w, flags} !== {to[i], tf[i]})
        $display("FAIL sub_%0d: lat=%0d out=%h flags=%b required lat=1 out=%h flags=%b",
                 i, lat, out_w, flags, to[i], tf[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_logic();
    logic [2:0]   lo[5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [W-1:0] la[5] = '{16'hF0F0, 16'h1234, 16'h0A0A, 16'hAAAA, 16'hC003};
    logic [W-1:0] lb[5] = '{16'h3C3C, 16'h00FF, 16'h5050, 16'hAAAA, 16'h0010};
    int   lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(lo[i], la[i], lb[i]);
      wait_valid(lat);
      e = sb_q.pop_front();
      n_total++;
      if (lat !== 1 || {out_w, flags} !== {e.res, e.flg})
        $display("FAIL logic_op%0d: lat=%0d out=%h flags=%b required lat=1 out=%h flags=%b",
                 lo[i], lat, out_w, flags, e.res, e.flg);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ma[3] = '{16'h0100, 16'h00FF, 16'hABCD};
    logic [W-1:0] mb[3] = '{16'h0100, 16'h0003, 16'h0000};
    int   lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(3'd7, ma[i], mb[i]);
      // Noise while BUSY: requests, operand changes and a stalled consumer.
      in_valid  = 1'b1;
      op        = 3'd0;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = 1'b0;
      wait_valid(lat);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      e = sb_q.pop_front();
      n_total++;
      if (lat !== 17) $display("FAIL mul_latency_%0d: got %0d required 17", i, lat);
      else n_pass++;
      n_total++;
      if ({out_w, flags} !== {e.res, e.flg})
        $display("FAIL mul_result_%0d: out=%h flags=%b required out=%h flags=%b",
                 i, out_w, flags, e.res, e.flg);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    issue(3'd4, 16'h0F0F, 16'h00FF);
    wait_valid(lat);
    e = sb_q.pop_front();
    n_total++;
    if (lat !== 1 || {out_w, flags} !== {e.res, e.flg})
      $display("FAIL bp_result: lat=%0d out=%h flags=%b required lat=1 out=%h flags=%b",
               lat, out_w, flags, e.res, e.flg);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({out_valid, in_ready, out_w} !== {1'b1, 1'b0, 16'h0FFF})
        $display("FAIL bp_hold_%0d: valid=%b ready=%b out=%h required 1 0 0fff",
                 i, out_valid, in_ready, out_w);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready, out_w} !== {1'b0, 1'b1, 16'h0FFF})
      $display("FAIL bp_retire: valid=%b ready=%b out=%h required 0 1 0fff", out_valid, in_ready, out_w);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    int   lat;
    exp_t e;
    issue(3'd7, 16'h1234, 16'h0077);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    void'(sb_q.pop_front());
    n_total++;
    if ({out_valid, in_ready, out_w, flags} !== {1'b0, 1'b0, 16'h0000, 4'h0})
      $display("FAIL abort_state: valid=%b ready=%b out=%h flags=%b required 0 0 0000 0000",
               out_valid, in_ready, out_w, flags);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL abort_release: in_ready=%b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
    issue(3'd0, 16'h7FFF, 16'h0001);
    wait_valid(lat);
    e = sb_q.pop_front();
    n_total++;
    if (lat !== 1 || {out_w, flags} !== {e.res, e.flg})
      $display("FAIL abort_next_op: lat=%0d out=%h flags=%b required lat=1 out=%h flags=%b",
               lat, out_w, flags, e.res, e.flg);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_shl();
    int   lat;
    exp_t e;
    issue(3'd6, 16'h0001, 16'h0013);
    op   = 3'd7;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    wait_valid(lat);
    e = sb_q.pop_front();
    n_total++;
    if (lat !== 1 || {out_w, flags} !== {e.res, e.flg} || out_w !== 16'h0008)
      $display("FAIL shl_capture: lat=%0d out=%h flags=%b required lat=1 out=0008 flags=%b",
               lat, out_w, flags, e.flg);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      issue(3'($urandom_range(0, 6)), W'($urandom), W'($urandom));
      wait_valid(lat);
      e = sb_q.pop_front();
      n_total++;
      if (lat !== 1 || {out_w, flags} !== {e.res, e.flg})
        $display("FAIL b2b_%0d: lat=%0d out=%h flags=%b required lat=1 out=%h flags=%b",
                 i, lat, out_w, flags, e.res, e.flg);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL b2b_done_ready_%0d: in_ready=%b required 0", i, in_ready);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    op        = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_shl();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
